// File: rtl/dpram_port_seq.sv
// Burst sequencer for one port of a true dual-port RAM: write/read bursts in, registered RAM port out.
// Optional macro DPRAM_PORT_SEQ_BOUNDARY_CHECK_EN rejects bursts that would run past the top address.
module dpram_port_seq #(
  parameter int WIDTH   = 8,
  parameter int ADDRESS = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDRESS-1:0] cmd_addr,
  input  logic [ADDRESS-1:0] cmd_len,
  input  logic               wdata_valid,
  output logic               wdata_ready,
  input  logic [WIDTH-1:0]   wdata,
  output logic               rdata_valid,
  output logic [WIDTH-1:0]   rdata,
  output logic               cmd_err,
  output logic               busy,
  output logic               ram_wr_en,
  output logic [ADDRESS-1:0] ram_addr,
  output logic [WIDTH-1:0]   ram_data_in,
  input  logic [WIDTH-1:0]   ram_data_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]         state_reg;
  logic [ADDRESS-1:0] cur_addr_reg;
  logic [ADDRESS-1:0] cnt_reg;
  // Bit 0: address presented to the RAM; bit 1: RAM output now holds that beat.
  logic [1:0]         pipe_reg;
  logic               ram_wr_en_reg;
  logic [ADDRESS-1:0] ram_addr_reg;
  logic [WIDTH-1:0]   ram_data_in_reg;

  logic cmd_fire;
  logic wdata_fire;
  logic cmd_reject;

  assign cmd_ready   = (state_reg == IDLE);
  assign wdata_ready = (state_reg == WRITE);
  assign busy        = (state_reg != IDLE);
  assign cmd_fire    = cmd_valid & cmd_ready;
  assign wdata_fire  = wdata_valid & wdata_ready;

  assign ram_wr_en   = ram_wr_en_reg;
  assign ram_addr    = ram_addr_reg;
  assign ram_data_in = ram_data_in_reg;
  assign rdata_valid = pipe_reg[1];
  assign rdata       = ram_data_out;

`ifdef DPRAM_PORT_SEQ_BOUNDARY_CHECK_EN
  logic [ADDRESS:0] cmd_end;
  logic             cmd_err_reg;

  // The carry out of start+len means the last beat would wrap past the top address.
  assign cmd_end    = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign cmd_reject = cmd_end[ADDRESS];
  assign cmd_err    = cmd_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_err_reg <= 1'b0;
    end else begin
      cmd_err_reg <= cmd_fire & cmd_reject;
    end
  end
`else
  assign cmd_reject = 1'b0;
  assign cmd_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_reg <= 2'b00;
    end else begin
      pipe_reg <= {pipe_reg[0], (state_reg == READ)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cur_addr_reg    <= '0;
      cnt_reg         <= '0;
      ram_wr_en_reg   <= 1'b0;
      ram_addr_reg    <= '0;
      ram_data_in_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          ram_wr_en_reg <= 1'b0;
          if (cmd_fire && !cmd_reject) begin
            cur_addr_reg <= cmd_addr;
            cnt_reg      <= cmd_len;
            state_reg    <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wdata_fire) begin
            ram_wr_en_reg   <= 1'b1;
            ram_addr_reg    <= cur_addr_reg;
            ram_data_in_reg <= wdata;
            cur_addr_reg    <= cur_addr_reg + 1'b1;
            if (cnt_reg == '0) begin
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end else begin
            ram_wr_en_reg <= 1'b0;
          end
        end
        READ: begin
          ram_wr_en_reg <= 1'b0;
          ram_addr_reg  <= cur_addr_reg;
          cur_addr_reg  <= cur_addr_reg + 1'b1;
          if (cnt_reg == '0) begin
            state_reg <= DRAIN;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DRAIN: begin
          ram_wr_en_reg <= 1'b0;
          // Leave once the last issued beat has moved into the output stage.
          if (!pipe_reg[0]) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_seq.sv
// Bench for dpram_port_seq: RAM model on the port, scoreboards for RAM writes and read beats.
module tb_dpram_port_seq;
  localparam int W     = 8;
  localparam int A     = 6;
  localparam int DEPTH = 64;
`ifdef DPRAM_PORT_SEQ_BOUNDARY_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [A-1:0] cmd_addr, cmd_len;
  logic         wdata_valid, wdata_ready;
  logic [W-1:0] wdata;
  logic         rdata_valid;
  logic [W-1:0] rdata;
  logic         cmd_err, busy, ram_wr_en;
  logic [A-1:0] ram_addr;
  logic [W-1:0] ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  dpram_port_seq #(.WIDTH(W), .ADDRESS(A)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .cmd_err(cmd_err), .busy(busy),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  // RAM port with registered output
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int data;} wr_t;
  wr_t wr_q[$];
  int  rd_q[$];
  int  wr_cycs[$], rd_cycs[$];
  int  ref_mem [DEPTH];
  int  data_q[$];
  int  wr_count = 0, rd_count = 0, err_cnt = 0, rdy_cnt = 0;
  int  accept_cyc = 0;
  int  tests = 0, fails = 0;
  wr_t mon_e;
  int  mon_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every RAM write and every read beat is checked against the expectation queues.
  initial begin
    forever begin
      @(negedge clk);
      if (ram_wr_en === 1'b1) begin
        wr_count++;
        wr_cycs.push_back(cyc);
        check("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          mon_e = wr_q.pop_front();
          check("wr_addr", 32'(ram_addr), mon_e.addr);
          check("wr_data", 32'(ram_data_in), mon_e.data);
        end
      end
      if (rdata_valid === 1'b1) begin
        rd_count++;
        rd_cycs.push_back(cyc);
        check("rd_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          mon_d = rd_q.pop_front();
          check("rd_data", 32'(rdata), mon_d);
        end
      end
      if (cmd_err === 1'b1) err_cnt++;
      if (wdata_ready === 1'b1) rdy_cnt++;
    end
  end

  function automatic bit rejected(input int a, input int l);
    return BCHK && (a + l > DEPTH - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit w, input int a, input int l);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a[A-1:0]; cmd_len = l[A-1:0];
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check("cmd_ready_timeout", 32'(n < 100), 1);
    tick();
    accept_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic send_wdata(input int d, input int stall);
    int n;
    n = 0;
    wdata_valid = 1'b0;
    repeat (stall) tick();
    wdata_valid = 1'b1; wdata = d[W-1:0];
    while (!wdata_ready && n < 100) begin tick(); n++; end
    check("wdata_ready_timeout", 32'(n < 100), 1);
    tick();
    wdata_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    check("idle_timeout", 32'(n < 300), 1);
    repeat (2) tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_cmd_ready", 32'(cmd_ready), 1);
  endtask

  // Queue the expected writes for a burst, update the reference memory, return the beat data.
  task automatic plan_write(input int a, input int l, output int beats[$]);
    int d;
    beats.delete();
    for (int i = 0; i <= l; i++) begin
      d = (data_q.size() != 0) ? data_q.pop_front() : int'($urandom_range(0, 255));
      beats.push_back(d);
      wr_q.push_back('{addr: (a + i) % DEPTH, data: d});
      ref_mem[(a + i) % DEPTH] = d;
    end
    data_q.delete();
  endtask

  task automatic write_burst(input int a, input int l, input int stall_at, input int stall_n);
    bit rej;
    int wr0, err0, rdy0, gap;
    int beats[$];
    rej = rejected(a, l);
    wr0 = wr_count; err0 = err_cnt; rdy0 = rdy_cnt;
    wr_cycs.delete();
    if (!rej) plan_write(a, l, beats);
    else data_q.delete();
    send_cmd(1'b1, a, l);
    if (!rej) begin
      foreach (beats[i]) send_wdata(beats[i], (i == stall_at) ? stall_n : 0);
    end else begin
      repeat (3) tick();
    end
    wait_idle();
    gap = (stall_at >= 1 && stall_at <= l) ? stall_n : 0;
    check("wr_pending", wr_q.size(), 0);
    check("wr_beats", wr_count - wr0, rej ? 0 : l + 1);
    check("wr_cmd_err", err_cnt - err0, rej ? 1 : 0);
    if (rej) check("wr_rej_wdata_ready", rdy_cnt - rdy0, 0);
    else if (wr_cycs.size() != 0) check("wr_span", wr_cycs[$] - wr_cycs[0], l + gap);
  endtask

  task automatic read_burst(input int a, input int l);
    bit rej;
    int rd0, err0;
    rej = rejected(a, l);
    rd0 = rd_count; err0 = err_cnt;
    rd_cycs.delete();
    if (!rej) for (int i = 0; i <= l; i++) rd_q.push_back(ref_mem[(a + i) % DEPTH]);
    send_cmd(1'b0, a, l);
    if (rej) repeat (3) tick();
    wait_idle();
    check("rd_pending", rd_q.size(), 0);
    check("rd_beats", rd_count - rd0, rej ? 0 : l + 1);
    check("rd_cmd_err", err_cnt - err0, rej ? 1 : 0);
    if (!rej && rd_cycs.size() != 0) begin
      check("rd_latency", rd_cycs[0] - accept_cyc, 2);
      check("rd_span", rd_cycs[$] - rd_cycs[0], l);
    end
  endtask

  initial begin
    int a, l, rd0, n, beats[$];
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 32'(ram_wr_en), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_data_in", 32'(ram_data_in), 0);
    check("rst_rdata_valid", 32'(rdata_valid), 0);
    check("rst_cmd_err", 32'(cmd_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_wdata_ready", 32'(wdata_ready), 0);
    rst = 1'b0;
    tick();

    // Fill the whole RAM with one maximum-length burst
    write_burst(0, DEPTH - 1, -1, 0);

    data_q = '{32'hB5, 32'h6F, 32'h11, 32'h22};
    write_burst(32'h28, 3, -1, 0);
    read_burst(32'h28, 3);

    write_burst($urandom_range(0, 40), 3, 1, 2);

    write_burst(32'h3E, 3, -1, 0);
    read_burst(32'h3E, 3);
    read_burst(0, 3);

    // Command held during a write burst is taken on the first IDLE cycle
    plan_write(32'h10, 3, beats);
    send_cmd(1'b1, 32'h10, 3);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h10; cmd_len = 6'd3;
    for (int i = 0; i <= 3; i++) rd_q.push_back(ref_mem[16 + i]);
    rd0 = rd_count;
    foreach (beats[i]) begin
      send_wdata(beats[i], (i == 1) ? 1 : 0);
      if (i < 3) check("held_cmd_ready_low", 32'(cmd_ready), 0);
    end
    check("held_cmd_ready_idle", 32'(cmd_ready), 1);
    tick();
    accept_cyc = cyc;
    cmd_valid = 1'b0;
    check("held_accepted_busy", 32'(busy), 1);
    check("held_accepted_ready", 32'(cmd_ready), 0);
    rd_cycs.delete();
    wait_idle();
    check("held_wr_pending", wr_q.size(), 0);
    check("held_rd_pending", rd_q.size(), 0);
    check("held_rd_beats", rd_count - rd0, 4);
    if (rd_cycs.size() != 0) check("held_rd_latency", rd_cycs[0] - accept_cyc, 2);

    for (int k = 0; k < 10; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) write_burst(a, l, $urandom_range(0, l), $urandom_range(0, 2));
      else read_burst(a, l);
    end

    // Reset in the middle of an 8-beat read after 3 beats have been delivered
    a = $urandom_range(0, DEPTH - 8);
    for (int i = 0; i <= 7; i++) rd_q.push_back(ref_mem[a + i]);
    rd0 = rd_count;
    send_cmd(1'b0, a, 7);
    n = 0;
    while (rd_count - rd0 < 3 && n < 100) begin @(negedge clk); #1; n++; end
    check("rst_mid_timeout", 32'(n < 100), 1);
    rst = 1'b1;
    rd_q.delete();
    @(negedge clk);
    #1;
    check("rst_mid_rdata_valid", 32'(rdata_valid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 1);
    check("rst_mid_addr", 32'(ram_addr), 0);
    rst = 1'b0;
    repeat (10) tick();
    check("rst_mid_beats", rd_count - rd0, 3);

    read_burst(a, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dpram_port_seq.md
Name: dpram_port_seq

Overview:
- Single-clock burst sequencer driving one port (A or B) of the true dual-port RAM.
- Accepts write/read burst commands over valid/ready, takes write data over a valid/ready stream, and emits read data as a valid-qualified stream.
- Generates the RAM port's wr_en/addr/data_in, all registered, and consumes the RAM's registered data_out.
- One instance per RAM port; each instance runs in that port's clock domain.

Parameters:
- WIDTH, 8, RAM data width in bits.
- ADDRESS, 6, RAM address width in bits; depth is 2^ADDRESS.

Ports:
- clk  in  1  sequencer clock; same clock as the RAM port it drives.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer accepts a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDRESS  burst start address.
- cmd_len  in  ADDRESS  beats minus 1; 0 = 1 beat, max = 2^ADDRESS beats.
- wdata_valid  in  1  write beat present.
- wdata_ready  out  1  sequencer accepts a write beat.
- wdata  in  WIDTH  write beat data.
- rdata_valid  out  1  read beat valid; no backpressure.
- rdata  out  WIDTH  read beat data.
- cmd_err  out  1  one-cycle pulse marking a rejected command (Optional Feature only).
- busy  out  1  high when state is not IDLE.
- ram_wr_en  out  1  to RAM wr_en.
- ram_addr  out  ADDRESS  to RAM addr.
- ram_data_in  out  WIDTH  to RAM data_in.
- ram_data_out  in  WIDTH  from RAM data_out; registered, valid the cycle after the RAM samples addr.

Behaviour:
- Reset values: state IDLE; all of the following are 0: ram_wr_en, ram_addr, ram_data_in, rdata_valid, cmd_err, busy, beat counter, read pipeline.
- Reset mid-burst: outputs reach reset values at the next edge. In-flight read beats are discarded; rdata_valid does not assert for them. The remainder of the burst is dropped.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1; all other states cmd_ready=0.
  - On an edge with cmd_valid&cmd_ready: latch cur_addr=cmd_addr and cnt=cmd_len.
  - Next state is WRITE if cmd_write=1, else READ.
  - ram_wr_en=0.
- WRITE:
  - wdata_ready=1 combinationally in WRITE only.
  - Edge with wdata_valid&wdata_ready: ram_wr_en<=1, ram_addr<=cur_addr, ram_data_in<=wdata, cur_addr<=cur_addr+1.
  - If cnt==0, go to IDLE; else cnt<=cnt-1.
  - Edge without a handshake: ram_wr_en<=0 and the counters hold.
- READ:
  - Every edge: ram_wr_en<=0, ram_addr<=cur_addr, issue bit shifted into a 2-stage pipeline, cur_addr+1.
  - cnt==0 goes to DRAIN; else cnt-1.
  - One beat is issued per cycle with no stalls.
- Read latency: a beat issued at edge k (ram_addr updated) is sampled by the RAM at k+1. rdata_valid=1 during the cycle after k+1. rdata = ram_data_out passthrough.
- DRAIN: ram_wr_en=0; go to IDLE when the pipeline is empty. Each read command produces exactly cmd_len+1 rdata_valid pulses, back to back.
- Address arithmetic is mod 2^ADDRESS: 2^ADDRESS-1 wraps to 0.
- ram_addr and ram_data_in hold their last values when no access is in progress.
- A cmd_valid while busy is not accepted; the command must be held by the source.

Optional Feature:
- Macro: DPRAM_PORT_SEQ_BOUNDARY_CHECK_EN.
- With the macro defined:
  - A command with cmd_addr+cmd_len > 2^ADDRESS-1 is handshaked, then rejected.
  - cmd_err=1 for the cycle after acceptance.
  - State stays IDLE, with no RAM access and no wdata_ready.
- Without the macro: bursts wrap to address 0 and cmd_err is tied to 0.

Test Plan:
- Write addr=0x28, len=3, wdata B5,6F,11,22 with no stall -> ram_wr_en high 4 consecutive cycles, addr 28,29,2A,2B with matching data; then busy=0 and cmd_ready=1.
- Read addr=0x28, len=3 after the above (RAM model attached) -> rdata_valid high 4 consecutive cycles, first valid 2 cycles after entering READ; rdata B5,6F,11,22.
- Write len=3 with wdata_valid low for 2 cycles after beat 1 -> ram_wr_en gap of 2 cycles; 4 writes total; addresses contiguous.
- Write addr=0x3E, len=3 -> without macro: addresses 3E,3F,00,01. With macro: cmd_err pulses once, ram_wr_en stays 0, wdata_ready stays 0.
- Read len=7, rst=1 after 3 rdata beats -> next cycle rdata_valid=0, busy=0, cmd_ready=1; no further rdata_valid.
- cmd_valid held during a write burst -> cmd_ready stays 0 until the burst ends; command accepted on the first IDLE cycle.
